res_mem_arbiter: RTL

//  Shares the single-port 16K x 8 result RAM (res_* bus) between two requesters:

---
 rtl/res_mem_arbiter_if.sv | 34 +++
 rtl/res_mem_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/res_mem_arbiter_if.sv
// Engine port, host port and result-RAM bus of res_mem_arbiter, bundled.
// The arbiter takes the slave view; requesters plus the RAM sit on the master side.
interface res_mem_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 8
) ();
  logic          e_req, e_wr, e_lock, e_gnt, e_rvalid;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic          h_req, h_wr, h_lock, h_gnt, h_rvalid;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata, h_rdata;
  logic          res_rd, res_wr;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_do, res_di;

  modport slave (
    input  e_req, e_wr, e_lock, e_addr, e_wdata,
    input  h_req, h_wr, h_lock, h_addr, h_wdata,
    input  res_di,
    output e_gnt, e_rvalid, e_rdata,
    output h_gnt, h_rvalid, h_rdata,
    output res_rd, res_wr, res_addr, res_do
  );

  modport master (
    output e_req, e_wr, e_lock, e_addr, e_wdata,
    output h_req, h_wr, h_lock, h_addr, h_wdata,
    output res_di,
    input  e_gnt, e_rvalid, e_rdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  res_rd, res_wr, res_addr, res_do
  );
endinterface

// File: rtl/res_mem_arbiter.sv
// Round-robin arbiter sharing the single-port result RAM between the DT engine (E)
// and the host DMA (H), with engine/host ownership locks bounded by MAX_LOCK.
module res_mem_arbiter #(
  parameter int AW       = 14,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 64
) (
  input  logic             clk,
  input  logic             reset,
  res_mem_arbiter_if.slave bus
);
  localparam int            CW       = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_E = 2'd1, OWN_H = 2'd2} state_t;

  state_t        state, state_nxt, own_tgt;
  logic          rr_h, rr_h_nxt;
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic          gnt_e, gnt_h, timeout;

  logic          acc_vld_p0, acc_wr_p0, acc_lock_p0, other_req_p0;
  logic [AW-1:0] acc_addr_p0;
  logic [DW-1:0] acc_wdata_p0;

  logic          res_rd_p1, res_wr_p1, vld_p1, host_p1;
  logic [AW-1:0] res_addr_p1;
  logic [DW-1:0] res_do_p1;
  logic          vld_p2, host_p2;

  // Stage p0: grant decision, combinational on the current requests
  always_comb begin
    gnt_e   = 1'b0;
    gnt_h   = 1'b0;
    timeout = 1'b0;
    case (state)
      OWN_E: begin
        timeout = bus.e_req & bus.h_req & (lock_cnt == LOCK_MAX);
        if (bus.e_req && !timeout) gnt_e = 1'b1;
        else if (bus.h_req)        gnt_h = 1'b1;
      end
      OWN_H: begin
        timeout = bus.h_req & bus.e_req & (lock_cnt == LOCK_MAX);
        if (bus.h_req && !timeout) gnt_h = 1'b1;
        else if (bus.e_req)        gnt_e = 1'b1;
      end
      default: begin
        if (bus.e_req && (!bus.h_req || !rr_h)) gnt_e = 1'b1;
        else if (bus.h_req)                     gnt_h = 1'b1;
      end
    endcase
  end

  always_comb begin
    acc_vld_p0   = gnt_e | gnt_h;
    acc_wr_p0    = gnt_h ? bus.h_wr    : bus.e_wr;
    acc_lock_p0  = gnt_h ? bus.h_lock  : bus.e_lock;
    other_req_p0 = gnt_h ? bus.e_req   : bus.h_req;
    acc_addr_p0  = gnt_h ? bus.h_addr  : bus.e_addr;
    acc_wdata_p0 = gnt_h ? bus.h_wdata : bus.e_wdata;
    own_tgt      = gnt_h ? OWN_H       : OWN_E;
  end

  always_comb begin
    state_nxt    = state;
    rr_h_nxt     = rr_h;
    lock_cnt_nxt = lock_cnt;
    if (acc_vld_p0) begin
      rr_h_nxt = gnt_e;
      if (timeout) begin
        state_nxt = IDLE;
      end else if (acc_lock_p0) begin
        state_nxt = own_tgt;
        // The entering grant is itself the first locked grant if the other side waits.
        if (state != own_tgt)  lock_cnt_nxt = CW'(other_req_p0);
        else if (other_req_p0) lock_cnt_nxt = lock_cnt + CW'(1);
      end else begin
        state_nxt = IDLE;
      end
    end else if ((state == OWN_E && !bus.e_lock) || (state == OWN_H && !bus.h_lock)) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_h     <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_h     <= rr_h_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Stage p1: registered RAM command; p2: read-return port tag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_rd_p1   <= 1'b0;
      res_wr_p1   <= 1'b0;
      res_addr_p1 <= '0;
      res_do_p1   <= '0;
      vld_p1      <= 1'b0;
      host_p1     <= 1'b0;
      vld_p2      <= 1'b0;
      host_p2     <= 1'b0;
    end else begin
      res_rd_p1 <= acc_vld_p0 & ~acc_wr_p0;
      res_wr_p1 <= acc_vld_p0 &  acc_wr_p0;
      if (acc_vld_p0) begin
        res_addr_p1 <= acc_addr_p0;
        res_do_p1   <= acc_wdata_p0;
      end
      vld_p1  <= acc_vld_p0 & ~acc_wr_p0;
      host_p1 <= gnt_h;
      vld_p2  <= vld_p1;
      host_p2 <= host_p1;
    end
  end

  assign bus.e_gnt    = gnt_e;
  assign bus.h_gnt    = gnt_h;
  assign bus.res_rd   = res_rd_p1;
  assign bus.res_wr   = res_wr_p1;
  assign bus.res_addr = res_addr_p1;
  assign bus.res_do   = res_do_p1;
  assign bus.e_rvalid = vld_p2 & ~host_p2;
  assign bus.h_rvalid = vld_p2 &  host_p2;
  assign bus.e_rdata  = bus.res_di;
  assign bus.h_rdata  = bus.res_di;
endmodule
